// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side bundle for uart_tx_fifo.
//   master : the producer that pushes words and clears the sticky flags.
//   slave  : the transmitter.
// Signals:
//   wr_en, wr_data  push request and word      (master -> slave)
//   clr_tx_done     clears tx_done and overflow (master -> slave)
//   full            FIFO holds FIFO_DEPTH words (slave -> master)
//   fifo_count      words queued, excluding the word on the wire
//   overflow        sticky: a write was dropped while full
//   tx              serial line, registered, idle high
//   busy            a frame is on the wire
//   tx_done         sticky: at least one frame completed
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  clr_tx_done;
  logic                  full;
  logic [CntW-1:0]       fifo_count;
  logic                  overflow;
  logic                  tx;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output wr_en, wr_data, clr_tx_done,
    input  full, fifo_count, overflow, tx, busy, tx_done
  );

  modport slave (
    input  wr_en, wr_data, clr_tx_done,
    output full, fifo_count, overflow, tx, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO. Queued words are sent back-to-back as
// frames of start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Ports:
//   clk    clock, all logic on posedge
//   rst_l  synchronous active-low reset; aborts any frame in flight
//   bus    uart_tx_fifo_if.slave (push side, status flags and the serial tx line)
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BAUD_PERIOD = 434,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          PARITY_EN   = 1'b0,
  parameter bit          PARITY_ODD  = 1'b0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic           clk,
  input  logic           rst_l,
  uart_tx_fifo_if.slave  bus
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(BAUD_PERIOD);
  // Counts data bits and, in the stop state, stop bits.
  localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_PERIOD - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] head;

  // Transmitter
  state_e                state_q, state_d;
  logic [BaudW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  baud_end, frame_end;

  // Sticky flags
  logic                  overflow_q, overflow_d, tx_done_q, tx_done_d;

  // full is taken from the registered count, so a same-cycle pop never frees a slot
  // for a write arriving in that cycle.
  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign push  = bus.wr_en & ~full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // tx_d is derived from the current state, so tx_q trails the state by one cycle;
  // every bit still lasts exactly BAUD_PERIOD clocks.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_d      = 1'b1;
    pop       = 1'b0;
    frame_end = 1'b0;
    baud_end  = (baud_q == BaudLast);

    if (state_q != StIdle) baud_d = baud_end ? '0 : baud_q + BaudW'(1);

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          par_d   = (^head) ^ PARITY_ODD;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (baud_end) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        tx_d = shreg_q[0];
        if (baud_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = PARITY_EN ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        tx_d = par_q;
        if (baud_end) begin
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_end) begin
          if (bit_q == StopLast) begin
            frame_end = 1'b1;
            bit_d     = '0;
            // Chain straight into the next frame when more words are queued.
            if (!empty) begin
              pop     = 1'b1;
              shreg_d = head;
              par_d   = (^head) ^ PARITY_ODD;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A set in the same cycle as clr_tx_done wins.
  always_comb begin
    overflow_d = (bus.wr_en & full) | (overflow_q & ~bus.clr_tx_done);
    tx_done_d  = frame_end | (tx_done_q & ~bus.clr_tx_done);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign bus.full       = full;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.tx_done    = tx_done_q;
endmodule
